// File: rtl/traffic_pkg.sv
// Shared types and constants for the actuated intersection scheduler.
// The round-robin helper picks the next phase to grant from the latched requests.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_ALL_RED,
        S_NS_GREEN,
        S_NS_YELLOW,
        S_EW_GREEN,
        S_EW_YELLOW,
        S_PED_WALK,
        S_PED_CLEAR
    } state_e;

    localparam logic [1:0] PH_NS   = 2'd0;
    localparam logic [1:0] PH_EW   = 2'd1;
    localparam logic [1:0] PH_PED  = 2'd2;
    localparam logic [1:0] PH_NONE = 2'd3;

    localparam int DEF_MIN_GREEN      = 10;
    localparam int DEF_MAX_GREEN      = 30;
    localparam int DEF_YELLOW_TIME    = 5;
    localparam int DEF_ALL_RED_TIME   = 2;
    localparam int DEF_WALK_TIME      = 15;
    localparam int DEF_PED_CLEAR_TIME = 6;
    localparam int DEF_CNT_W          = 6;

    // First requesting phase after 'last' in NS->EW->PED order; NS when nothing waits.
    function automatic logic [1:0] rr_next(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] o0;
        logic [1:0] o1;
        logic [1:0] o2;
        logic [1:0] pick;
        case (last)
            PH_NS:   begin o0 = PH_EW;  o1 = PH_PED; o2 = PH_NS;  end
            PH_EW:   begin o0 = PH_PED; o1 = PH_NS;  o2 = PH_EW;  end
            default: begin o0 = PH_NS;  o1 = PH_EW;  o2 = PH_PED; end
        endcase
        pick = PH_NS;
        if (req[o0])      pick = o0;
        else if (req[o1]) pick = o1;
        else if (req[o2]) pick = o2;
        return pick;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// State-dwell counter: clears on state entry, saturates at all-ones, and
// registers "count >= limit-1" where limit belongs to the state being entered/held.
module phase_timer #(
    parameter int CNT_W         = 6,
    parameter bit RESET_REACHED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             reached
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (clear)
            count_next = '0;
        else if (count != CNT_MAX)
            count_next = count + CNT_W'(1);
    end

    // limit is always >= 1, so limit-1 never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            reached <= RESET_REACHED;
        end else begin
            count   <= count_next;
            reached <= (count_next >= (limit - CNT_W'(1)));
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Actuated three-phase intersection controller (NS, EW, pedestrian) with
// latched requests, round-robin service, min/max green and clearance intervals.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN      = DEF_MIN_GREEN,
    parameter int MAX_GREEN      = DEF_MAX_GREEN,
    parameter int YELLOW_TIME    = DEF_YELLOW_TIME,
    parameter int ALL_RED_TIME   = DEF_ALL_RED_TIME,
    parameter int WALK_TIME      = DEF_WALK_TIME,
    parameter int PED_CLEAR_TIME = DEF_PED_CLEAR_TIME,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ns_sensor,
    input  logic       ew_sensor,
    input  logic       ped_btn,
    output logic       NS_Red,
    output logic       NS_Yellow,
    output logic       NS_Green,
    output logic       EW_Red,
    output logic       EW_Yellow,
    output logic       EW_Green,
    output logic       walk,
    output logic       dont_walk_flash,
    output logic [1:0] phase,
    output logic [2:0] pending
);

    localparam logic [CNT_W-1:0] L_MIN_GREEN  = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] L_YELLOW     = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] L_ALL_RED    = CNT_W'(ALL_RED_TIME);
    localparam logic [CNT_W-1:0] L_WALK       = CNT_W'(WALK_TIME);
    localparam logic [CNT_W-1:0] L_PED_CLEAR  = CNT_W'(PED_CLEAR_TIME);
    localparam logic [CNT_W-1:0] MAX_LAST     = CNT_W'(MAX_GREEN - 1);

    state_e           state;
    state_e           state_next;
    logic [1:0]       last_served;
    logic [1:0]       grant;
    logic [2:0]       serve_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] limit_next;
    logic             reached;
    logic             entering;

    assign entering = (state_next != state);

    phase_timer #(
        .CNT_W         (CNT_W),
        .RESET_REACHED (ALL_RED_TIME <= 1)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (entering),
        .limit   (limit_next),
        .count   (count),
        .reached (reached)
    );

    always_comb begin
        state_next = state;
        grant      = rr_next(pending, last_served);
        case (state)
            S_ALL_RED: if (reached) begin
                case (grant)
                    PH_EW:   state_next = S_EW_GREEN;
                    PH_PED:  state_next = S_PED_WALK;
                    default: state_next = S_NS_GREEN;
                endcase
            end
            S_NS_GREEN:
                if ((pending[2] | pending[1]) && reached && (!ns_sensor || count >= MAX_LAST))
                    state_next = S_NS_YELLOW;
            S_EW_GREEN:
                if ((pending[2] | pending[0]) && reached && (!ew_sensor || count >= MAX_LAST))
                    state_next = S_EW_YELLOW;
            S_NS_YELLOW: if (reached) state_next = S_ALL_RED;
            S_EW_YELLOW: if (reached) state_next = S_ALL_RED;
            S_PED_WALK:  if (reached) state_next = S_PED_CLEAR;
            S_PED_CLEAR: if (reached) state_next = S_ALL_RED;
            default:     state_next = S_ALL_RED;
        endcase
    end

    // Timer limit follows the state that will be occupied after this edge.
    always_comb begin
        limit_next = L_ALL_RED;
        case (state_next)
            S_NS_GREEN, S_EW_GREEN:   limit_next = L_MIN_GREEN;
            S_NS_YELLOW, S_EW_YELLOW: limit_next = L_YELLOW;
            S_PED_WALK:               limit_next = L_WALK;
            S_PED_CLEAR:              limit_next = L_PED_CLEAR;
            default:                  limit_next = L_ALL_RED;
        endcase
    end

    assign serve_next = {state_next == S_PED_WALK,
                         state_next == S_EW_GREEN,
                         state_next == S_NS_GREEN};

    // Clearing by serve_next covers both the entry edge and the whole service interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_ALL_RED;
            pending     <= 3'b000;
            last_served <= PH_PED;
        end else begin
            state   <= state_next;
            pending <= (pending | {ped_btn, ew_sensor, ns_sensor}) & ~serve_next;
            if (entering && serve_next[0])      last_served <= PH_NS;
            else if (entering && serve_next[1]) last_served <= PH_EW;
            else if (entering && serve_next[2]) last_served <= PH_PED;
        end
    end

    always_comb begin
        NS_Green        = (state == S_NS_GREEN);
        NS_Yellow       = (state == S_NS_YELLOW);
        NS_Red          = !(NS_Green || NS_Yellow);
        EW_Green        = (state == S_EW_GREEN);
        EW_Yellow       = (state == S_EW_YELLOW);
        EW_Red          = !(EW_Green || EW_Yellow);
        walk            = (state == S_PED_WALK);
        dont_walk_flash = (state == S_PED_CLEAR);
        case (state)
            S_NS_GREEN, S_NS_YELLOW: phase = PH_NS;
            S_EW_GREEN, S_EW_YELLOW: phase = PH_EW;
            S_PED_WALK, S_PED_CLEAR: phase = PH_PED;
            default:                 phase = PH_NONE;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus random traffic,
// compared every cycle against a phase/stage reference model.
module tb_traffic_phase_scheduler;

    localparam int MIN_GREEN      = 10;
    localparam int MAX_GREEN      = 30;
    localparam int YELLOW_TIME    = 5;
    localparam int ALL_RED_TIME   = 2;
    localparam int WALK_TIME      = 15;
    localparam int PED_CLEAR_TIME = 6;
    localparam int SAT            = 63;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ns_sensor = 1'b0;
    logic       ew_sensor = 1'b0;
    logic       ped_btn = 1'b0;
    logic       NS_Red, NS_Yellow, NS_Green, EW_Red, EW_Yellow, EW_Green;
    logic       walk, dont_walk_flash;
    logic [1:0] phase;
    logic [2:0] pending;

    traffic_phase_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ns_sensor       (ns_sensor),
        .ew_sensor       (ew_sensor),
        .ped_btn         (ped_btn),
        .NS_Red          (NS_Red),
        .NS_Yellow       (NS_Yellow),
        .NS_Green        (NS_Green),
        .EW_Red          (EW_Red),
        .EW_Yellow       (EW_Yellow),
        .EW_Green        (EW_Green),
        .walk            (walk),
        .dont_walk_flash (dont_walk_flash),
        .phase           (phase),
        .pending         (pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: served phase (0 NS, 1 EW, 2 PED, 3 all-red), stage
    // (0 = go interval, 1 = clearance interval), elapsed cycles, request bits.
    int m_ph, m_stage, m_t, m_last;
    bit m_pend[3];

    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];
    int cur_ns, last_ns, cur_walk, last_walk;
    bit prev_ns_g, prev_ew_g, prev_walk;

    localparam logic [12:0] RESET_VEC = 13'b100_100_00_11_000;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] obs_vec();
        return {NS_Red, NS_Yellow, NS_Green, EW_Red, EW_Yellow, EW_Green,
                walk, dont_walk_flash, phase, pending};
    endfunction

    function automatic logic [12:0] exp_vec();
        logic [1:0] ph;
        ph = 2'(m_ph);
        return {m_ph != 0, m_ph == 0 && m_stage == 1, m_ph == 0 && m_stage == 0,
                m_ph != 1, m_ph == 1 && m_stage == 1, m_ph == 1 && m_stage == 0,
                m_ph == 2 && m_stage == 0, m_ph == 2 && m_stage == 1,
                ph, m_pend[2], m_pend[1], m_pend[0]};
    endfunction

    function automatic int model_pick();
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (m_last + k) % 3;
            if (m_pend[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_ph = 3; m_stage = 0; m_t = 0; m_last = 2;
        for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
    endtask

    task automatic model_step(bit ns, bit ew, bit ped);
        int nph, nst, dur;
        bit own, other;
        bit req[3];
        nph = m_ph; nst = m_stage;
        req[0] = ns; req[1] = ew; req[2] = ped;
        if (m_ph == 3) begin
            if (m_t == ALL_RED_TIME - 1) begin nph = model_pick(); nst = 0; end
        end else if (m_stage == 0 && m_ph < 2) begin
            own   = (m_ph == 0) ? ns : ew;
            other = (m_ph == 0) ? (m_pend[1] | m_pend[2]) : (m_pend[0] | m_pend[2]);
            if (other && m_t >= MIN_GREEN - 1 && (!own || m_t >= MAX_GREEN - 1)) nst = 1;
        end else if (m_stage == 0) begin
            if (m_t == WALK_TIME - 1) nst = 1;
        end else begin
            dur = (m_ph == 2) ? PED_CLEAR_TIME : YELLOW_TIME;
            if (m_t == dur - 1) begin nph = 3; nst = 0; end
        end
        for (int i = 0; i < 3; i++)
            m_pend[i] = (m_pend[i] | req[i]) && !(nph == i && nst == 0);
        if (nph != m_ph || nst != m_stage) begin
            m_t = 0;
            if (nst == 0 && nph != 3) m_last = nph;
        end else begin
            m_t = (m_t < SAT) ? m_t + 1 : SAT;
        end
        m_ph = nph; m_stage = nst;
    endtask

    task automatic track();
        if (NS_Green) cur_ns++;
        else if (cur_ns > 0) begin last_ns = cur_ns; cur_ns = 0; end
        if (walk) cur_walk++;
        else if (cur_walk > 0) begin last_walk = cur_walk; cur_walk = 0; end
        if (NS_Green && !prev_ns_g) obs_q.push_back(2'd0);
        if (EW_Green && !prev_ew_g) obs_q.push_back(2'd1);
        if (walk && !prev_walk)     obs_q.push_back(2'd2);
        prev_ns_g = NS_Green; prev_ew_g = EW_Green; prev_walk = walk;
    endtask

    task automatic cycle(bit ns, bit ew, bit ped, string tag);
        ns_sensor = ns; ew_sensor = ew; ped_btn = ped;
        @(posedge clk);
        model_step(ns, ew, ped);
        @(negedge clk);
        check(tag, 32'(obs_vec()), 32'(exp_vec()));
        track();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ns_sensor = 1'b0; ew_sensor = 1'b0; ped_btn = 1'b0;
        model_reset();
        obs_q.delete();
        cur_ns = 0; last_ns = 0; cur_walk = 0; last_walk = 0;
        prev_ns_g = 1'b0; prev_ew_g = 1'b0; prev_walk = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(obs_vec()), 32'(RESET_VEC));
        rst_n = 1'b1;
    endtask

    task automatic check_order(string tag);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check(tag, 32'(obs_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;

        // Idle after reset: two all-red cycles, then NS rests.
        do_reset();
        repeat (2) cycle(0, 0, 0, "s1_all_red");
        check("s1_phase_none_end", 32'(phase), 32'd0);
        repeat (70) cycle(0, 0, 0, "s1_rest");
        check("s1_ns_rest", 32'(NS_Green & EW_Red), 32'd1);

        // EW pulse at NS green cycle 3, NS sensor quiet.
        do_reset();
        repeat (2) cycle(0, 0, 0, "s2_all_red");
        repeat (3) cycle(0, 0, 0, "s2_green");
        cycle(0, 1, 0, "s2_ew_pulse");
        check("s2_pending", 32'(pending), 32'b010);
        repeat (20) cycle(0, 0, 0, "s2_run");
        check("s2_ns_green_len", 32'(last_ns), 32'(MIN_GREEN));
        check("s2_ew_green", 32'(EW_Green), 32'd1);
        check("s2_ew_pend_clr", 32'(pending[1]), 32'd0);

        // During EW green: ped and NS together -> PED served before NS.
        repeat (3) cycle(0, 0, 0, "s4_ew_green");
        cycle(1, 0, 1, "s4_pulse");
        repeat (45) cycle(0, 0, 0, "s4_run");
        check("s4_walk_len", 32'(last_walk), 32'(WALK_TIME));
        check("s4_ns_green", 32'(NS_Green), 32'd1);
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd0};
        check_order("s4_order");

        // NS sensor held with EW waiting: green capped at MAX_GREEN.
        do_reset();
        repeat (2) cycle(0, 0, 0, "s3_all_red");
        cycle(1, 1, 0, "s3_pulse");
        repeat (40) cycle(1, 0, 0, "s3_hold");
        check("s3_ns_green_len", 32'(last_ns), 32'(MAX_GREEN));

        // All three requests at once: round-robin from NS.
        do_reset();
        cycle(1, 1, 1, "s5_pulse");
        repeat (90) cycle(0, 0, 0, "s5_run");
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd0};
        check_order("s5_order");

        // Asynchronous reset in the third NS yellow cycle.
        do_reset();
        repeat (2) cycle(0, 0, 0, "s6_all_red");
        repeat (3) cycle(0, 0, 0, "s6_green");
        cycle(0, 1, 0, "s6_ew_pulse");
        guard = 0;
        while (!NS_Yellow && guard < 40) begin
            cycle(0, 0, 0, "s6_wait");
            guard++;
        end
        check("s6_yellow_seen", 32'(NS_Yellow), 32'd1);
        repeat (2) cycle(0, 0, 0, "s6_yellow");
        #2 rst_n = 1'b0;
        #1 check("s6_async_reset", 32'(obs_vec()), 32'(RESET_VEC));
        do_reset();
        repeat (2) cycle(0, 0, 0, "s6_restart_all_red");
        repeat (20) cycle(0, 0, 0, "s6_restart_rest");
        check("s6_restart_ns", 32'(NS_Green), 32'd1);

        // Random traffic against the model.
        do_reset();
        repeat (800) begin
            bit r_ns, r_ew, r_ped;
            r_ns  = ($urandom_range(0, 3) == 0);
            r_ew  = ($urandom_range(0, 3) == 0);
            r_ped = ($urandom_range(0, 15) == 0);
            cycle(r_ns, r_ew, r_ped, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
